// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter:
// FSM state encoding, owner codes, access size codes and byte-count decode.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_IF   = 2'b01;
  localparam logic [1:0] OWNER_MEM  = 2'b10;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  // An instruction fetch always moves one full 32-bit word.
  localparam logic [2:0] IF_BYTES   = 3'd4;

  // Number of bytes moved for a load/store size code; 2'b11 is also a word.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane.sv
// Byte-lane helper for the memory arbiter: inserts a received RAM byte into
// the word being assembled, and extracts the next store byte from a word.
module mem_arb_lane
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [7:0]  ins_byte,
  input  logic [1:0]  ins_idx,
  output logic [31:0] word_out,
  input  logic [31:0] ext_word,
  input  logic [1:0]  ext_idx,
  output logic [7:0]  ext_byte
);

  // Little-endian insert: byte k lands in bits [8k+7:8k], other lanes kept.
  always_comb begin
    word_out = word_in;
    word_out[{ins_idx, 3'b000} +: 8] = ins_byte;
  end

  // Little-endian extract: store bytes leave from the low end first.
  always_comb begin
    ext_byte = ext_word[{ext_idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide RAM between an instruction-fetch client and a
// load/store client. Load/store wins ties; transfers run one byte per cycle.
// Optional build macro MEM_ARB_IF_ABORT_EN lets a load/store request abort a
// fetch that has not yet issued its last address; the fetch is then redone.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              stall_req_o,
  output logic [1:0]        owner_o
);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic [2:0]  cnt_last;
  logic [1:0]  owner_q;
  logic [31:0] asm_q;
  logic [31:0] wdata_q;
  logic        if_done_q;

  logic        start_if;
  logic        start_mem;
  logic        advance;
  logic        capture;
  logic        finish;
  logic        in_xfer;

  logic [31:0] lane_word;
  logic [7:0]  lane_byte;
  logic [1:0]  ins_idx;
  logic [1:0]  ext_idx;

  assign cnt_last = n_q - 3'd1;
  assign in_xfer  = (state_q == ST_IF_RD) || (state_q == ST_MEM_RD) ||
                    (state_q == ST_MEM_WR);

  // The byte on ram_din_i belongs to the address issued one cycle earlier,
  // so reads capture lane cnt-1; writes prepare lane cnt+1 for the next cycle.
  assign ins_idx = cnt_q[1:0] - 2'd1;
  assign ext_idx = cnt_q[1:0] + 2'd1;

  mem_arb_lane u_lane (
    .word_in  (asm_q),
    .ins_byte (ram_din_i),
    .ins_idx  (ins_idx),
    .word_out (lane_word),
    .ext_word (wdata_q),
    .ext_idx  (ext_idx),
    .ext_byte (lane_byte)
  );

  // A flush in the fetch completion cycle cancels the strobe combinationally.
  assign if_done_o   = if_done_q & ~if_flush_i;
  assign stall_req_o = mem_req_i & ~mem_done_o;

  // Owner follows the state; the completion cycle reports whoever finished.
  always_comb begin
    owner_o = OWNER_IDLE;
    case (state_q)
      ST_IF_RD:  owner_o = OWNER_IF;
      ST_MEM_RD: owner_o = OWNER_MEM;
      ST_MEM_WR: owner_o = OWNER_MEM;
      ST_DONE:   owner_o = owner_q;
      default:   owner_o = OWNER_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus the per-cycle datapath controls.
  always_comb begin
    state_d   = state_q;
    start_if  = 1'b0;
    start_mem = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          start_mem = 1'b1;
          state_d   = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
        end else if (if_req_i) begin
          start_if = 1'b1;
          state_d  = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        capture = (cnt_q != 3'd0);
        if (if_flush_i) begin
          state_d = ST_IDLE;
        end
`ifdef MEM_ARB_IF_ABORT_EN
        else if (mem_req_i && (cnt_q < cnt_last)) begin
          start_mem = 1'b1;
          state_d   = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
        end
`endif
        else if (cnt_q == n_q) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          advance = (cnt_q < cnt_last);
        end
      end
      ST_MEM_RD: begin
        capture = (cnt_q != 3'd0);
        if (cnt_q == n_q) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          advance = (cnt_q < cnt_last);
        end
      end
      ST_MEM_WR: begin
        if (cnt_q == cnt_last) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: address walk, byte counter, read assembly, write bytes, strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      n_q         <= '0;
      owner_q     <= OWNER_IDLE;
      asm_q       <= '0;
      wdata_q     <= '0;
      if_done_q   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
      ram_a_o     <= '0;
      ram_dout_o  <= '0;
      ram_wr_o    <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_o <= 1'b0;
      ram_wr_o   <= 1'b0;
      if (start_mem) begin
        owner_q <= OWNER_MEM;
        ram_a_o <= mem_addr_i;
        n_q     <= byte_count(mem_len_i);
        cnt_q   <= '0;
        asm_q   <= '0;
        wdata_q <= mem_wdata_i;
        if (mem_we_i) begin
          ram_wr_o   <= 1'b1;
          ram_dout_o <= mem_wdata_i[7:0];
        end
      end else if (start_if) begin
        owner_q <= OWNER_IF;
        ram_a_o <= if_addr_i;
        n_q     <= IF_BYTES;
        cnt_q   <= '0;
        asm_q   <= '0;
      end else if (in_xfer) begin
        cnt_q <= cnt_q + 3'd1;
        if (capture) asm_q <= lane_word;
        if (advance) begin
          ram_a_o <= ram_a_o + ADDR_W'(1);
          if (state_q == ST_MEM_WR) begin
            ram_wr_o   <= 1'b1;
            ram_dout_o <= lane_byte;
          end
        end
        if (finish) begin
          case (state_q)
            ST_IF_RD: begin
              if_data_o <= lane_word;
              if_done_q <= 1'b1;
            end
            ST_MEM_RD: begin
              mem_rdata_o <= lane_word;
              mem_done_o  <= 1'b1;
            end
            default: begin
              mem_done_o <= 1'b1;
            end
          endcase
        end
      end
      if (state_d == ST_IDLE) cnt_q <= '0;
    end
  end

endmodule
